// File: rtl/fft_seq_ctrl.sv
// Sample-collection and sequencing front end for a 16-point FFT stage chain.
// Gathers real samples into frames, hands them to the core and captures the result.
module fft_seq_ctrl #(
    parameter int CORE_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [15:0]  in_data,
    output logic [511:0] core_in,
    input  logic [511:0] core_out,
    output logic         out_valid,
    output logic [511:0] out_data,
    output logic         busy,
    output logic [7:0]   frame_cnt
);

    // state | meaning
    // FILL  | collecting samples, no result pending
    // WAIT  | frame handed to core, counting lat until core_out is valid
    typedef enum logic {FILL = 1'b0, WAIT = 1'b1} state_t;

    localparam logic [3:0] LAT_TC = 4'(CORE_LAT - 1);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [3:0]   r_idx;
    logic [3:0]   r_lat;
    logic [15:0]  r_buf [16];
    logic [511:0] r_core_in;
    logic [511:0] r_out_data;
    logic         r_out_valid;
    logic [7:0]   r_frame_cnt;
    logic [511:0] w_frame;
    logic         w_load;
    logic         w_capture;

    assign w_load = in_valid && (r_idx == 4'd15);

    // Word 15 comes straight from the input so the frame is handed over on the same edge.
    always_comb begin
        w_frame = '0;
        for (int k = 0; k < 15; k++) begin
            w_frame[32*k +: 32] = {r_buf[k], 16'h0000};
        end
        w_frame[511:480] = {in_data, 16'h0000};
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            FILL: if (w_load) w_state_nxt = WAIT;
            WAIT: if (r_lat == LAT_TC) begin
                w_capture   = 1'b1;
                w_state_nxt = FILL;
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_lat       <= '0;
            r_core_in   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_frame_cnt <= '0;
            for (int k = 0; k < 16; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            if (in_valid) begin
                r_buf[r_idx] <= in_data;
                r_idx        <= r_idx + 4'd1;
            end
            if (w_load) begin
                r_core_in <= w_frame;
            end
            if (r_state == WAIT && !w_capture) begin
                r_lat <= r_lat + 4'd1;
            end else begin
                r_lat <= '0;
            end
            if (w_capture) begin
                r_out_data  <= core_out;
                r_out_valid <= 1'b1;
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign core_in   = r_core_in;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign frame_cnt = r_frame_cnt;
    assign busy      = (r_state == WAIT);

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Self-checking bench: two instances (core latency 1 and 15) on shared stimulus,
// checked every cycle against a frame-level model plus directed tables and sequences.
module tb_fft_seq_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [15:0]  in_data = '0;
    logic [511:0] key;
    logic [511:0] ci1, ci15, co1, co15, od1, od15;
    logic         ov1, ov15, bz1, bz15;
    logic [7:0]   fc1, fc15;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // The stand-in FFT core is a fixed XOR of the frame it is given.
    assign co1  = ci1 ^ key;
    assign co15 = ci15 ^ key;

    fft_seq_ctrl #(.CORE_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .core_in(ci1), .core_out(co1), .out_valid(ov1), .out_data(od1),
        .busy(bz1), .frame_cnt(fc1));

    fft_seq_ctrl #(.CORE_LAT(15)) u_dut15 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .core_in(ci15), .core_out(co15), .out_valid(ov15), .out_data(od15),
        .busy(bz15), .frame_cnt(fc15));

    // Reference model: sample list per frame, result due at a cycle timestamp.
    int           lat_of [2] = '{1, 15};
    int           cyc = 0;
    int           m_n [2];
    logic [15:0]  m_buf [2][16];
    logic [511:0] m_core [2];
    logic [511:0] m_out [2];
    bit           m_pend [2];
    int           m_due [2];
    bit           m_ov [2];
    logic [7:0]   m_fc [2];
    int           pulses [2];

    function automatic logic [511:0] pack16(input logic [15:0] s [16]);
        logic [511:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[32*k +: 32] = {s[k], 16'h0000};
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_n[i] = 0; m_core[i] = '0; m_out[i] = '0; m_pend[i] = 0;
            m_due[i] = 0; m_ov[i] = 0; m_fc[i] = 8'd0;
            for (int k = 0; k < 16; k++) m_buf[i][k] = '0;
        end
    endtask

    task automatic model_edge();
        cyc++;
        for (int i = 0; i < 2; i++) begin
            m_ov[i] = 0;
            if (m_pend[i] && cyc == m_due[i]) begin
                m_ov[i] = 1; m_out[i] = m_core[i] ^ key;
                m_fc[i] = m_fc[i] + 8'd1; m_pend[i] = 0;
            end
            if (in_valid) begin
                m_buf[i][m_n[i]] = in_data;
                m_n[i]++;
                if (m_n[i] == 16) begin
                    m_core[i] = pack16(m_buf[i]);
                    m_n[i] = 0; m_pend[i] = 1; m_due[i] = cyc + lat_of[i];
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_all();
        chk("core_in_l1", ci1, m_core[0]);    chk("core_in_l15", ci15, m_core[1]);
        chk("out_valid_l1", ov1, m_ov[0]);    chk("out_valid_l15", ov15, m_ov[1]);
        chk("out_data_l1", od1, m_out[0]);    chk("out_data_l15", od15, m_out[1]);
        chk("busy_l1", bz1, m_pend[0]);       chk("busy_l15", bz15, m_pend[1]);
        chk("frame_cnt_l1", fc1, m_fc[0]);    chk("frame_cnt_l15", fc15, m_fc[1]);
        if (ov1)  pulses[0]++;
        if (ov15) pulses[1]++;
    endtask

    task automatic step(input logic v, input logic [15:0] d);
        in_valid = v; in_data = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       v;
        logic [15:0] d;
        logic       ov;
        logic       bz;
        logic [7:0] fc;
    } vec_t;

    vec_t         tbl [18];
    logic [15:0]  sbuf [16];
    logic [511:0] exp_frame;

    initial begin
        key = {16{$urandom()}};
        for (int i = 0; i < 18; i++) begin
            tbl[i].v  = (i < 16);
            tbl[i].d  = 16'h0100;
            tbl[i].ov = (i == 16);
            tbl[i].bz = (i == 15);
            tbl[i].fc = (i >= 16) ? 8'd1 : 8'd0;
        end
        model_reset();
        @(negedge clk);
        reset_now();

        // Back-to-back frame of 1.0 with core latency 1
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].v, tbl[i].d);
            chk($sformatf("tbl%0d_out_valid", i), ov1, tbl[i].ov);
            chk($sformatf("tbl%0d_busy", i), bz1, tbl[i].bz);
            chk($sformatf("tbl%0d_frame_cnt", i), fc1, tbl[i].fc);
        end
        chk("tbl_core_in", ci1, {16{32'h01000000}});
        chk("tbl_out_data", od1, {16{32'h01000000}} ^ key);

        // Gapped input: valid every other cycle
        for (int j = 0; j < 32; j++) step((j % 2) == 0, 16'((j / 2) * 16));
        for (int j = 0; j < 16; j++) step(1'b0, 16'h0);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("gap_word%0d", k), ci15[32*k +: 32], {16'(k * 16), 16'h0000});
        end

        // Reset after 9 samples, then one full frame
        for (int j = 0; j < 9; j++) step(1'b1, 16'($urandom()));
        reset_now();
        pulses = '{0, 0};
        for (int k = 0; k < 16; k++) begin
            sbuf[k] = 16'($urandom());
            step(1'b1, sbuf[k]);
        end
        for (int j = 0; j < 20; j++) step(1'b0, 16'h0);
        exp_frame = pack16(sbuf);
        chk("rstmid_core_in", ci1, exp_frame);
        chk("rstmid_pulses_l1", 512'(pulses[0]), 512'd1);
        chk("rstmid_pulses_l15", 512'(pulses[1]), 512'd1);

        // Reset one cycle before the latency-15 result would appear
        reset_now();
        for (int k = 0; k < 16; k++) step(1'b1, 16'($urandom()));
        for (int j = 0; j < 14; j++) step(1'b0, 16'h0);
        reset_now();
        pulses = '{0, 0};
        chk("rstwait_out_data", od15, 512'd0);
        chk("rstwait_busy", bz15, 1'b0);
        for (int j = 0; j < 20; j++) step(1'b0, 16'h0);
        chk("rstwait_pulses", 512'(pulses[1]), 512'd0);

        // 256 continuous frames wrap the frame counter
        reset_now();
        for (int f = 0; f < 256; f++) begin
            for (int k = 0; k < 16; k++) begin
                step(1'b1, (f == 255 && k == 3) ? 16'hFF00 : 16'($urandom()));
            end
        end
        chk("neg_word3", ci15[127:96], 32'hFF000000);
        for (int j = 0; j < 16; j++) step(1'b0, 16'h0);
        chk("wrap_fc_l1", fc1, 8'd0);
        chk("wrap_fc_l15", fc15, 8'd0);
        for (int k = 0; k < 16; k++) step(1'b1, 16'($urandom()));
        for (int j = 0; j < 16; j++) step(1'b0, 16'h0);
        chk("wrap_next_fc_l1", fc1, 8'd1);
        chk("wrap_next_fc_l15", fc15, 8'd1);

        // Random gapped traffic against the model
        reset_now();
        for (int j = 0; j < 1500; j++) begin
            step($urandom_range(0, 9) < 7, 16'($urandom()));
        end
        for (int j = 0; j < 20; j++) step(1'b0, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
